// File: rtl/cg_rate_accumulator.sv
// cg_rate_accumulator: accumulates one coefficient group's CABAC rate (flag + sign cost),
// saturating at 32 bits, and returns it with nonzero/coefficient counts over valid/ready.
module cg_rate_accumulator #(
    parameter int MAX_COEFFS = 16,
    parameter int CW = $clog2(MAX_COEFFS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    input  logic          coeff_valid,
    output logic          coeff_ready,
    input  logic [15:0]   coeff_abs,
    input  logic          coeff_last,
    input  logic [31:0]   flag_cost,
    input  logic [31:0]   sign_cost,
    output logic          rate_valid,
    input  logic          rate_ready,
    output logic [31:0]   rate,
    output logic [CW-1:0] nz_count,
    output logic [CW-1:0] coeff_count,
    output logic          truncated
);
    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;
    state_t        state_q, state_d;
    logic [31:0]   rate_q, rate_d;
    logic [CW-1:0] nz_q, nz_d, cnt_q, cnt_d;
    logic          trunc_q, trunc_d;
    logic          nonzero, accept, close;
    logic [32:0]   addend;
    logic [33:0]   sum;
    always_comb begin
        nonzero = coeff_abs != '0;
        accept  = state_q == ACCUM && coeff_valid;
        addend  = {1'b0, flag_cost} + (nonzero ? {1'b0, sign_cost} : 33'd0);
        sum     = {2'b00, rate_q} + {1'b0, addend};
        close   = coeff_last || (cnt_q + CW'(1) == CW'(MAX_COEFFS));
        state_d = state_q;
        rate_d  = rate_q;
        nz_d    = nz_q;
        cnt_d   = cnt_q;
        trunc_d = trunc_q;
        if (state_q == IDLE && start) begin
            state_d = ACCUM;
            rate_d  = '0;
            nz_d    = '0;
            cnt_d   = '0;
            trunc_d = 1'b0;
        end else if (accept) begin
            // a saturated accumulator stays saturated since addends are non-negative
            rate_d  = |sum[33:32] ? 32'hFFFF_FFFF : sum[31:0];
            nz_d    = nz_q + CW'(nonzero);
            cnt_d   = cnt_q + CW'(1);
            state_d = close ? OUTPUT : ACCUM;
            trunc_d = close ? !coeff_last : trunc_q;
        end else if (state_q == OUTPUT && rate_ready) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rate_q  <= '0;
            nz_q    <= '0;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rate_q  <= rate_d;
            nz_q    <= nz_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end
    assign busy        = state_q != IDLE;
    assign coeff_ready = state_q == ACCUM;
    assign rate_valid  = state_q == OUTPUT;
    assign rate        = rate_q;
    assign nz_count    = nz_q;
    assign coeff_count = cnt_q;
    assign truncated   = trunc_q;
endmodule

// File: tb/tb_cg_rate_accumulator.sv
// tb_cg_rate_accumulator: directed and randomized groups checked against a saturating-sum reference model.
module tb_cg_rate_accumulator;
    localparam int CW = 5;
    logic          clk = 0, rst = 1, start = 0, coeff_valid = 0, coeff_last = 0, rate_ready = 0;
    logic [15:0]   coeff_abs = 0;
    logic [31:0]   flag_cost = 0, sign_cost = 0;
    logic          busy, coeff_ready, rate_valid, truncated;
    logic [31:0]   rate;
    logic [CW-1:0] nz_count, coeff_count;
    int            errors = 0, checks = 0;
    logic [15:0]   abs_a[16];
    logic [31:0]   fc_a[16], sc_a[16];
    int            gap_a[16];

    cg_rate_accumulator #(.MAX_COEFFS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .coeff_valid(coeff_valid), .coeff_ready(coeff_ready), .coeff_abs(coeff_abs),
        .coeff_last(coeff_last), .flag_cost(flag_cost), .sign_cost(sign_cost),
        .rate_valid(rate_valid), .rate_ready(rate_ready), .rate(rate),
        .nz_count(nz_count), .coeff_count(coeff_count), .truncated(truncated)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] a, input logic [31:0] fc, input logic [31:0] sc);
        for (int i = 0; i < 16; i++) begin
            abs_a[i] = a;
            fc_a[i]  = fc;
            sc_a[i]  = sc;
            gap_a[i] = 0;
        end
    endtask

    task automatic drive_group(input string nm, input int n, input bit last, input int hold);
        longint s = 0;
        int     nz = 0;
        for (int i = 0; i < n; i++) begin
            s += longint'(fc_a[i]) + (abs_a[i] != 0 ? longint'(sc_a[i]) : 0);
            if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
            nz += (abs_a[i] != 0) ? 1 : 0;
        end
        start = 1;
        tick;
        start = 0;
        checks++;
        if (coeff_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s open: coeff_ready=%b busy=%b expected 1 1", nm, coeff_ready, busy);
        end
        for (int i = 0; i < n; i++) begin
            repeat (gap_a[i]) begin
                start = 1;
                tick;
            end
            start       = 0;
            coeff_valid = 1;
            coeff_abs   = abs_a[i];
            flag_cost   = fc_a[i];
            sign_cost   = sc_a[i];
            coeff_last  = last && (i == n - 1);
            tick;
            coeff_valid = 0;
            coeff_last  = 0;
        end
        checks++;
        if (rate_valid !== 1'b1 || coeff_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s close: rate_valid=%b coeff_ready=%b expected 1 0", nm, rate_valid, coeff_ready);
        end
        checks++;
        if (rate !== s[31:0] || nz_count !== CW'(nz) || coeff_count !== CW'(n) || truncated !== !last) begin
            errors++;
            $display("FAIL %s result: rate=%0h nz=%0d cnt=%0d trunc=%b expected %0h %0d %0d %b",
                     nm, rate, nz_count, coeff_count, truncated, s[31:0], nz, n, !last);
        end
        repeat (hold) begin
            start      = 1;
            rate_ready = 0;
            tick;
            checks++;
            if (rate_valid !== 1'b1 || coeff_ready !== 1'b0 || rate !== s[31:0] ||
                nz_count !== CW'(nz) || coeff_count !== CW'(n) || truncated !== !last) begin
                errors++;
                $display("FAIL %s hold: valid=%b ready=%b rate=%0h nz=%0d cnt=%0d expected 1 0 %0h %0d %0d",
                         nm, rate_valid, coeff_ready, rate, nz_count, coeff_count, s[31:0], nz, n);
            end
        end
        start      = 0;
        rate_ready = 1;
        tick;
        rate_ready = 0;
        checks++;
        if (rate_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s release: rate_valid=%b busy=%b expected 0 0", nm, rate_valid, busy);
        end
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) tick;
        checks++;
        if ({busy, coeff_ready, rate_valid, truncated} !== 4'b0 || rate !== 0 || nz_count !== 0 || coeff_count !== 0) begin
            errors++;
            $display("FAIL reset: busy=%b ready=%b valid=%b rate=%0h nz=%0d cnt=%0d expected all 0",
                     busy, coeff_ready, rate_valid, rate, nz_count, coeff_count);
        end
        rst = 0;
        tick;
    endtask

    task automatic test_reset_mid_accum;
        start = 1;
        tick;
        start = 0;
        for (int i = 0; i < 3; i++) begin
            coeff_valid = 1;
            coeff_abs   = 16'd5;
            flag_cost   = 32'd7000;
            sign_cost   = 32'd32768;
            tick;
        end
        coeff_valid = 0;
        rst = 1;
        #1;
        checks++;
        if ({busy, coeff_ready, rate_valid, truncated} !== 4'b0 || rate !== 0 || nz_count !== 0 || coeff_count !== 0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b ready=%b valid=%b rate=%0h nz=%0d cnt=%0d expected all 0",
                     busy, coeff_ready, rate_valid, rate, nz_count, coeff_count);
        end
        tick;
        rst = 0;
        tick;
        fill(16'd0, 32'd1000, 32'd32768);
        drive_group("after_reset", 1, 1, 0);
    endtask

    task automatic test_group4;
        fill(16'd0, 32'd5000, 32'd32768);
        abs_a[0] = 16'd3;
        abs_a[2] = 16'd1;
        drive_group("group4", 4, 1, 0);
    endtask

    task automatic test_truncate;
        fill(16'd1, 32'd0, 32'd32768);
        drive_group("truncate", 16, 0, 0);
    endtask

    task automatic test_saturation;
        fill(16'd2, 32'hFFFF_0000, 32'd32768);
        drive_group("saturate", 2, 1, 0);
    endtask

    task automatic test_backpressure;
        fill(16'd4, 32'd1234, 32'd32768);
        drive_group("backpressure", 2, 1, 5);
    endtask

    task automatic test_gaps;
        fill(16'd1, 32'd300, 32'd32768);
        gap_a[1] = 2;
        drive_group("gaps", 2, 1, 0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 25; k++) begin
            int n;
            bit last;
            n    = $urandom_range(1, 16);
            last = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++) begin
                abs_a[i] = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom);
                fc_a[i]  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 100000));
                sc_a[i]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 65535)) : 32'd32768;
                gap_a[i] = $urandom_range(0, 2);
            end
            drive_group("random", n, last, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset;
        test_reset_mid_accum;
        test_group4;
        test_truncate;
        test_saturation;
        test_backpressure;
        test_gaps;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cg_rate_accumulator.md
# cg_rate_accumulator

Downstream consumer of the fixed sign-bit-cost stage in the CABAC bit rate estimator. Accumulates the estimated rate of one coefficient group for RDOQ: per-coefficient context-coded flag cost plus the sign cost for every nonzero level. It delivers a saturated 32-bit total and a nonzero count through a valid/ready output handshake. It sits between the per-coefficient cost stages (context-flag cost and sign cost) and the RDOQ rate-distortion comparator.

## Interface
Parameters:
- MAX_COEFFS, 16, maximum coefficients per group; the group closes when this many have been accepted.
- CW, $clog2(MAX_COEFFS+1), width of the coefficient and nonzero counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that opens a new group; honoured only in IDLE.
- busy  out  1  high in ACCUM and OUTPUT.
- coeff_valid  in  1  coefficient bundle valid.
- coeff_ready  out  1  high only in ACCUM.
- coeff_abs  in  16  absolute quantized level.
- coeff_last  in  1  last coefficient of the group.
- flag_cost  in  32  context-coded flag cost for this coefficient (fixed-point, 32768 = 1 bit).
- sign_cost  in  32  sign cost from the sign stage (normally 32768).
- rate_valid  out  1  result valid; held until accepted.
- rate_ready  in  1  result accepted when high with rate_valid.
- rate  out  32  saturated group rate.
- nz_count  out  CW  number of nonzero levels in the group.
- coeff_count  out  CW  number of coefficients accepted.
- truncated  out  1  group closed by reaching MAX_COEFFS without coeff_last.

## Operation
- FSM states: IDLE, ACCUM, OUTPUT.
- IDLE: on start=1, clear the accumulator, nz and coeff counters, and truncated, then go to ACCUM. rate_valid=0.
- ACCUM: coeff_ready=1. A coefficient is accepted when coeff_valid && coeff_ready.
  - addend = flag_cost + (coeff_abs != 0 ? sign_cost : 0), computed 33 bits wide.
  - acc_next = acc + addend, computed 34 bits wide and clamped to 32'hFFFF_FFFF if it exceeds 32 bits. Once saturated, the accumulator stays saturated.
  - coeff_count increments on every accepted coefficient. nz_count increments when coeff_abs != 0.
  - The group closes on an accepted coefficient when coeff_last=1 or coeff_count+1 == MAX_COEFFS. On close, register rate, nz_count and coeff_count including that coefficient, and set truncated = !coeff_last. Then go to OUTPUT.
- OUTPUT: rate_valid=1, and all result outputs are held stable. On rate_ready=1, go to IDLE and drop rate_valid.
- start in ACCUM or OUTPUT is ignored, with no effect on the accumulation.
- start and coeff_valid in the same IDLE cycle: only start is acted on; the coefficient is not accepted (coeff_ready=0).

## Timing
- Reset (async assert, any state): state=IDLE; rate=0, nz_count=0, coeff_count=0, truncated=0, rate_valid=0, coeff_ready=0, busy=0. Any partial group is discarded.
- start accepted at edge N, so coeff_ready=1 from cycle N+1.
- Coefficient accepted at edge M is reflected in the accumulator at M+1.
- Closing coefficient accepted at edge M gives rate_valid=1 from cycle M+1. coeff_ready=0 from M+1.
- Minimum occupancy for a single-coefficient group is 3 cycles, start to IDLE, with rate_ready tied high.
- rate_ready while rate_valid=0 is ignored.
- Back-to-back groups: start may be asserted in the cycle after the rate handshake.
- All outputs are registered. coeff_ready and rate_valid are decoded from registered state only, with no input-to-output combinational path.

## Test plan
- Reset mid-ACCUM after 3 coefficients, then release → all outputs 0, state IDLE. A new start with one coefficient (abs=0, flag_cost=1000, last) → rate=1000, nz_count=0, coeff_count=1.
- Group of 4 with abs={3,0,1,0}, flag_cost=5000 each, sign_cost=32768, last on the 4th → rate=85536, nz_count=2, coeff_count=4, truncated=0, rate_valid one cycle after the 4th accept.
- 16 coefficients, all abs=1, flag_cost=0, no coeff_last → close on the 16th with rate=524288, nz_count=16, coeff_count=16, truncated=1.
- Saturation: 2 coefficients with flag_cost=32'hFFFF_0000, abs=2 → rate=32'hFFFF_FFFF.
- Backpressure: hold rate_ready=0 for 5 cycles → rate_valid and outputs stable, coeff_ready=0, start ignored. Raise rate_ready → IDLE next cycle.
- coeff_valid toggling with gaps (valid 1,0,0,1 with last) → only the 2 valid beats are counted. start asserted in ACCUM has no effect.
